// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU writeback stage: condition codes,
// the architectural flags struct and the branch-condition evaluator.
package alu_pkg;

  localparam int REGBITS_DEFAULT = 4;
  localparam int DATA_W          = 32;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_Z  = 3'd1;
  localparam logic [2:0] COND_NZ = 3'd2;
  localparam logic [2:0] COND_N  = 3'd3;
  localparam logic [2:0] COND_NN = 3'd4;
  localparam logic [2:0] COND_C  = 3'd5;
  localparam logic [2:0] COND_NC = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

  function automatic logic cond_eval(input logic [2:0] cond, input flags_t f);
    logic r;
    case (cond)
      COND_AL: r = 1'b1;
      COND_Z:  r = f.z;
      COND_NZ: r = ~f.z;
      COND_N:  r = f.n;
      COND_NN: r = ~f.n;
      COND_C:  r = f.c;
      COND_NC: r = ~f.c;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Register-write queue: {dest, data} entries with push, pop and flush, plus a
// per-entry valid/dest view used by the hazard compare.
module wb_fifo #(
  parameter int DEPTH   = 2,
  parameter int REGBITS = 4,
  parameter int DATA_W  = 32
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             flush,
  input  logic [REGBITS-1:0]               push_dest,
  input  logic [DATA_W-1:0]                push_data,
  output logic [$clog2(DEPTH):0]           count,
  output logic [REGBITS-1:0]               head_dest,
  output logic [DATA_W-1:0]                head_data,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REGBITS-1:0]    ent_dest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]                 count_q, count_d;
  logic [DEPTH-1:0][REGBITS-1:0]  dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0]   data_q, data_d;
  logic                           do_push, do_pop;
  logic [PTR_W-1:0]               offset;

  assign do_push = push & (count_q != FULL);
  assign do_pop  = pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dest_d   = dest_q;
    data_d   = data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        dest_d[wr_ptr_q] = push_dest;
        data_d[wr_ptr_q] = push_data;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    offset    = '0;
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PTR_W'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offset} < count_q);
    end
  end

  assign ent_dest  = dest_q;
  assign count     = count_q;
  assign head_dest = dest_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits architectural flags, queues register writes,
// evaluates branch conditions and answers read-after-write hazard queries.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int REGBITS = REGBITS_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_c,
  input  logic                in_carry,
  input  logic                in_zero,
  input  logic                in_neg,
  input  logic [REGBITS-1:0]  in_dest,
  input  logic                in_wen,
  input  logic                in_setf,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [REGBITS-1:0]  wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                flag_c,
  output logic                flag_z,
  output logic                flag_n,
  output logic                carry_fb,
  input  logic [2:0]          cond,
  output logic                cond_true,
  input  logic [REGBITS-1:0]  hazard_addr,
  output logic                hazard,
  input  logic                flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  flags_t                         flags_q, flags_d;
  logic [PTR_W:0]                 count;
  logic [DEPTH-1:0]               ent_valid;
  logic [DEPTH-1:0][REGBITS-1:0]  ent_dest;
  logic                           accept, push, pop;

  // No pass-through when full: a same-cycle pop does not open in_ready.
  assign in_ready = ~flush & (count != FULL);
  assign accept   = in_valid & in_ready;
  assign push     = accept & in_wen;
  assign wb_valid = (count != '0);
  assign pop      = wb_valid & wb_ready;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .REGBITS (REGBITS),
    .DATA_W  (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_dest (in_dest),
    .push_data (in_c),
    .count     (count),
    .head_dest (wb_addr),
    .head_data (wb_data),
    .ent_valid (ent_valid),
    .ent_dest  (ent_dest)
  );

  always_comb begin
    flags_d = flags_q;
    if (accept && in_setf) begin
      flags_d = '{c: in_carry, z: in_zero, n: in_neg};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign carry_fb  = flags_q.c;
  assign cond_true = cond_eval(cond, flags_q);

  // Only queued entries count; the write being accepted now is not visible.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_dest[i] == hazard_addr)) begin
        hazard = 1'b1;
      end
    end
  end

endmodule
